// File: rtl/operand_fetch.sv
// operand_fetch: indirect operand fetch, reads pointer mem[pc] then operand mem[pointer]
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   start, pc, ready              fetch request from the sequencer (accepted only while ready)
//   valid, ack                    result handshake, result held until ack
//   opnd_addr, opnd_data, err     operand address, signed operand, read timeout flag
//   mem_rd_en, mem_addr           one-cycle memory read request
//   mem_rd_data, mem_rd_valid     memory read response
// Optional build macro OPERAND_FETCH_TIMEOUT_EN adds a per-read wait limit of TIMEOUT cycles.
module operand_fetch #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  ready,
    output logic                  valid,
    input  logic                  ack,
    output logic [ADDR_WIDTH-1:0] opnd_addr,
    output logic [WIDTH-1:0]      opnd_data,
    output logic                  err,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_rd_data,
    input  logic                  mem_rd_valid
);
    typedef enum logic [2:0] {IDLE, REQ_PTR, WAIT_PTR, REQ_OPND, WAIT_OPND, DONE} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, opnd_addr_q, opnd_addr_d, ptr;
    logic [WIDTH-1:0]      opnd_data_q, opnd_data_d;
    logic                  waiting, expired;
    assign waiting   = state_q == WAIT_PTR || state_q == WAIT_OPND;
    assign ready     = state_q == IDLE;
    assign valid     = state_q == DONE;
    assign mem_rd_en = state_q == REQ_PTR || state_q == REQ_OPND;
    assign mem_addr  = state_q == REQ_PTR ? pc_q : state_q == REQ_OPND ? opnd_addr_q : '0;
    assign opnd_addr = opnd_addr_q;
    assign opnd_data = opnd_data_q;
    // The pointer is an unsigned address: zero-extend narrow data words, truncate wide ones.
    generate
        if (ADDR_WIDTH > WIDTH) begin : g_zext
            assign ptr = {{(ADDR_WIDTH-WIDTH){1'b0}}, mem_rd_data};
        end else begin : g_trunc
            assign ptr = mem_rd_data[ADDR_WIDTH-1:0];
        end
    endgenerate
`ifdef OPERAND_FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    // Counter is zero in every non-wait state, so it is already clear on entering WAIT_*.
    assign expired = waiting && !mem_rd_valid && cnt_q == CW'(TIMEOUT - 1);
    assign err     = err_q;
    always_comb begin
        cnt_d = waiting && !mem_rd_valid ? cnt_q + CW'(1) : '0;
        err_d = expired ? 1'b1 : (state_q == DONE && ack) ? 1'b0 : err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        opnd_addr_d = opnd_addr_q;
        opnd_data_d = opnd_data_q;
        case (state_q)
            IDLE: begin
                pc_d    = start ? pc : pc_q;
                state_d = start ? REQ_PTR : IDLE;
            end
            REQ_PTR:  state_d = WAIT_PTR;
            WAIT_PTR: begin
                if (mem_rd_valid) begin
                    opnd_addr_d = ptr;
                    state_d     = REQ_OPND;
                end else if (expired) begin
                    opnd_addr_d = '0;
                    opnd_data_d = '0;
                    state_d     = DONE;
                end
            end
            REQ_OPND: state_d = WAIT_OPND;
            WAIT_OPND: begin
                if (mem_rd_valid || expired) begin
                    opnd_data_d = mem_rd_valid ? mem_rd_data : '0;
                    state_d     = DONE;
                end
            end
            DONE:     state_d = ack ? IDLE : DONE;
            default:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            opnd_addr_q <= '0;
            opnd_data_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            opnd_addr_q <= opnd_addr_d;
            opnd_data_q <= opnd_data_d;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench for operand_fetch with a behavioural fetch model and memory
module tb_operand_fetch;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, ack = 1'b0;
    logic [7:0] pc = '0;
    logic       ready, valid, err, mem_rd_en, mem_rd_valid;
    logic [7:0] opnd_addr, opnd_data, mem_addr, mem_rd_data;
    logic [7:0] mem [256];
    int         tests = 0, fails = 0;
    bit         chk_en = 1'b0;
    int         lat = 1;
    logic       spur = 1'b0, resp_v = 1'b0;
    int         cnt = 0;
    logic [7:0] raddr = '0;
    int         e = 0, m_n = 0, m_lat = 0, m_d = 0;
    bit         m_busy = 1'b0, m_err = 1'b0;
    logic [7:0] m_pc = '0, m_pa = '0, m_pd = '0, m_addr = '0, m_data = '0;

    operand_fetch #(.WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .ready(ready), .valid(valid), .ack(ack),
        .opnd_addr(opnd_addr), .opnd_data(opnd_data), .err(err), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, req, e);
        end
    endtask

    // Memory: answers a request 'lat' cycles after the request cycle; lat=0 never answers.
    // Spurious strobes carry junk data so a wrongly captured strobe shows up in the results.
    assign mem_rd_valid = resp_v | spur;
    assign mem_rd_data  = resp_v ? mem[raddr] : 8'hEE;
    always @(negedge clk) begin
        resp_v = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) resp_v = 1'b1;
        end
        if (mem_rd_en && lat > 0) begin
            cnt   = lat;
            raddr = mem_addr;
        end
    end

    // Fetch model: a fetch accepted at edge n resolves to mem[mem[pc]]; with memory latency L the
    // pointer is known at edge n+1+L and the result is presented from edge n+2+2L until acked.
    always @(posedge clk) begin
        e++;
        if (rst) begin
            m_busy = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
        end else if (m_busy) begin
            if (e - 1 >= m_n + m_d && ack) begin
                m_busy = 1'b0;
                m_err  = 1'b0;
            end else begin
                if (m_lat > 0 && e == m_n + 1 + m_lat) m_addr = m_pa;
                if (e == m_n + m_d) begin
                    m_data = m_lat > 0 ? m_pd : 8'h00;
                    if (m_lat == 0) begin m_addr = '0; m_err = 1'b1; end
                end
            end
        end else if (start) begin
            m_busy = 1'b1; m_n = e; m_lat = lat; m_pc = pc;
            m_pa = mem[pc]; m_pd = mem[mem[pc]];
`ifdef OPERAND_FETCH_TIMEOUT_EN
            m_d = lat > 0 ? 2 + 2 * lat : 16;
`else
            m_d = lat > 0 ? 2 + 2 * lat : 1 << 30;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", ready, !m_busy);
            chk("valid", valid, m_busy && e >= m_n + m_d);
            chk("mem_rd_en", mem_rd_en, m_busy && (e == m_n || (m_lat > 0 && e == m_n + 1 + m_lat)));
            if (mem_rd_en) chk("mem_addr", mem_addr, e == m_n ? m_pc : m_pa);
            chk("opnd_addr", opnd_addr, m_addr);
            chk("opnd_data", opnd_data, m_data);
            chk("err", err, m_err);
        end
    end

    task automatic go(input logic [7:0] p);
        pc = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 8'h22; mem[8'h22] = 8'hFB;
        mem[8'h40] = 8'h55; mem[8'h55] = 8'h7F;
        mem[8'h30] = 8'h90; mem[8'h90] = 8'h80;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_ready", ready, 1);
        chk("reset_valid", valid, 0);
        // Basic fetch with 1-cycle memory
        lat = 1;
        go(8'h10);
        chk("basic_req_ptr_en", mem_rd_en, 1);
        chk("basic_req_ptr_addr", mem_addr, 8'h10);
        repeat (2) @(negedge clk);
        chk("basic_req_opnd_addr", mem_addr, 8'h22);
        @(negedge clk);
        chk("basic_valid_early", valid, 0);
        @(negedge clk);
        chk("basic_valid_n4", valid, 1);
        chk("basic_opnd_addr", opnd_addr, 8'h22);
        chk("basic_opnd_data", opnd_data, 8'hFB);
        // Backpressure: ack withheld 10 cycles, start pulsed meanwhile
        repeat (4) @(negedge clk);
        go(8'h40);
        repeat (5) @(negedge clk);
        chk("bp_valid_held", valid, 1);
        chk("bp_data_held", opnd_data, 8'hFB);
        chk("bp_no_rd", mem_rd_en, 0);
        do_ack();
        chk("bp_ready_after_ack", ready, 1);
        chk("bp_valid_after_ack", valid, 0);
        // Mid-run reset held 2 cycles
        go(8'h10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_opnd_data", opnd_data, 0);
        chk("rst_err", err, 0);
        repeat (3) @(negedge clk);
        // 3-cycle memory with spurious strobes in IDLE and REQ_PTR
        lat = 3;
        spur = 1'b1;
        @(negedge clk);
        go(8'h40);
        @(negedge clk);
        spur = 1'b0;
        repeat (6) @(negedge clk);
        chk("lat_valid_early", valid, 0);
        @(negedge clk);
        chk("lat_valid_n8", valid, 1);
        chk("lat_opnd_addr", opnd_addr, 8'h55);
        chk("lat_opnd_data", opnd_data, 8'h7F);
        do_ack();
        // Abort during WAIT_OPND; late response lands in IDLE
        go(8'h10);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", ready, 1);
        repeat (4) @(negedge clk);
        chk("abort_idle_valid", valid, 0);
        lat = 1;
        go(8'h30);
        repeat (4) @(negedge clk);
        chk("abort_new_valid", valid, 1);
        chk("abort_new_addr", opnd_addr, 8'h90);
        chk("abort_new_data", opnd_data, 8'h80);
        do_ack();
        // Memory that never responds
        lat = 0;
        go(8'h10);
`ifdef OPERAND_FETCH_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("to_valid_early", valid, 0);
        @(negedge clk);
        chk("to_valid", valid, 1);
        chk("to_err", err, 1);
        chk("to_data", opnd_data, 0);
        do_ack();
        chk("to_err_cleared", err, 0);
`else
        repeat (100) @(negedge clk);
        chk("hang_ready", ready, 0);
        chk("hang_err", err, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
